// File: rtl/alu8_pkg.sv
// Shared width default and opcode encodings for the 8-bit pipelined ALU.
package alu8_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu8_core.sv
// Purely combinational ALU operation: WIDTH-bit operands in, WIDTH+1-bit result out.
module alu8_core
   import alu8_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic [WIDTH:0]   result
);

   // The top bit carries the carry, borrow or shifted-out bit; it is zero for logic ops.
   always_comb begin
      result = '0;
      case (sel)
         OP_ADD:  result = {1'b0, a} + {1'b0, b};
         OP_SUB:  result = {1'b0, a} - {1'b0, b};
         OP_AND:  result = {1'b0, a & b};
         OP_OR:   result = {1'b0, a | b};
         OP_XOR:  result = {1'b0, a ^ b};
         OP_NOT:  result = {1'b0, ~a};
         OP_SHL:  result = {a, 1'b0};
         OP_SHR:  result = {2'b00, a[WIDTH-1:1]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu8.sv
// Two-stage pipelined ALU: operand registers, combinational core, registered result.
module alu8
   import alu8_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic [WIDTH:0]   result
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       sel_q;
   logic [WIDTH:0]   op_result;

   // Stage 1: capture the operation; a low rst discards anything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= '0;
      end else begin
         a_q   <= a;
         b_q   <= b;
         sel_q <= sel;
      end
   end

   alu8_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (a_q),
      .b      (b_q),
      .sel    (sel_q),
      .result (op_result)
   );

   // Stage 2: register the computed value so the output never depends on live inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
      end else begin
         result <= op_result;
      end
   end

endmodule

// File: tb/tb_alu8.sv
// Scoreboard bench for alu8: stimulus pushes expected results, a monitor pops them on time.
module tb_alu8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] sel;
   logic [8:0] result;

   typedef struct {
      logic [8:0] expected;
      int         dueCycle;
      string      tag;
   } scoreEntry_t;

   scoreEntry_t scoreQ[$];
   int cycleCount = 0;
   int nChecks    = 0;
   int nErrors    = 0;

   logic [7:0] dirA   [12] = '{8'd3, 8'd3, 8'd3, 8'hFF, 8'd3, 8'd4,
                               8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h81, 8'h81};
   logic [7:0] dirB   [12] = '{8'd4, 8'd4, 8'd4, 8'h01, 8'd4, 8'd3,
                               8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00};
   logic [2:0] dirSel [12] = '{3'd0, 3'd6, 3'd7, 3'd0, 3'd1, 3'd1,
                               3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [8:0] dirExp [12] = '{9'h007, 9'h006, 9'h001, 9'h100, 9'h1FF, 9'h001,
                               9'h030, 9'h0FC, 9'h0CC, 9'h00F, 9'h102, 9'h040};

   alu8 dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .sel    (sel),
      .result (result)
   );

   always #5 clk = ~clk;

   // Reference model in plain integer arithmetic, folded into nine bits.
   function automatic logic [8:0] refModel(int x, int y, int op);
      int r;
      case (op)
         0:       r = x + y;
         1:       r = (x - y + 512) % 512;
         2:       r = x & y;
         3:       r = x | y;
         4:       r = x ^ y;
         5:       r = 255 - x;
         6:       r = x * 2;
         7:       r = x / 2;
         default: r = 0;
      endcase
      return r[8:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [8:0] expected);
      nChecks++;
      if (result !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: result=%h expected=%h cycle=%0d", tag, result, expected, cycleCount);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op,
                                input logic [8:0] expected, input string tag);
      a   = x;
      b   = y;
      sel = op;
      scoreQ.push_back('{expected: expected, dueCycle: cycleCount + 2, tag: tag});
   endtask

   task automatic applyRandom();
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] op;
      x  = 8'($urandom);
      y  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      applyStimulus(x, y, op, refModel(int'(x), int'(y), int'(op)), "random");
   endtask

   // Monitor: each result is checked just after the edge on which it is due.
   initial begin : monitor
      scoreEntry_t entry;
      forever begin
         @(posedge clk);
         cycleCount++;
         #1;
         while (scoreQ.size() > 0 && scoreQ[0].dueCycle <= cycleCount) begin
            entry = scoreQ.pop_front();
            nChecks++;
            if (entry.dueCycle < cycleCount) begin
               nErrors++;
               $display("[TB] FAIL %s_late: due cycle=%0d seen cycle=%0d", entry.tag, entry.dueCycle, cycleCount);
            end else if (result !== entry.expected) begin
               nErrors++;
               $display("[TB] FAIL %s: result=%h expected=%h cycle=%0d", entry.tag, result, entry.expected, cycleCount);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      a   = 8'($urandom);
      b   = 8'($urandom);
      sel = 3'($urandom_range(0, 7));

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("reset_hold", 9'h000);
         a   = 8'($urandom);
         b   = 8'($urandom);
         sel = 3'($urandom_range(0, 7));
      end

      // Release: the first edge shows the cleared stage, then the directed ops follow.
      @(negedge clk);
      rst = 1'b1;
      scoreQ.push_back('{expected: 9'h000, dueCycle: cycleCount + 1, tag: "post_release"});
      applyStimulus(dirA[0], dirB[0], dirSel[0], dirExp[0], "directed");
      for (int k = 1; k < 12; k++) begin
         @(negedge clk);
         applyStimulus(dirA[k], dirB[k], dirSel[k], dirExp[k], "directed");
      end

      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (i == 500) begin
            #2 rst = 1'b0;
            #1 checkOutput("async_clear", 9'h000);
            scoreQ.delete();
            @(negedge clk);
            checkOutput("reset_held", 9'h000);
            rst = 1'b1;
            scoreQ.push_back('{expected: 9'h000, dueCycle: cycleCount + 1, tag: "post_pulse"});
         end
         applyRandom();
      end

      for (int i = 0; i < 6 && scoreQ.size() > 0; i++) begin
         @(negedge clk);
      end
      if (scoreQ.size() > 0) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL drain: pending=%0d required=0", scoreQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
